wheel_resistance_controller: RTL and testbench
==============================================

// Module: wheel_resistance_controller
// PURPOSE
//   Converts resistance-level commands into the 8-bit duty word consumed by
//   wheel_resistance_driver.PWM_in.
//   Clamps each command to a safe duty window and slews the output toward it
//   in fixed steps, one step per PWM period, so the brake never jumps.
//   An emergency stop forces zero resistance immediately.
// PARAMETERS
//   W         8    duty/level width; must equal the driver's PWM_in width
//   RAMP_DIV  256  clocks between slew steps; 2^W = one driver PWM period
//   STEP      4    max duty change per step (1..2^W-1)
//   DUTY_MIN  0    lowest duty the output may settle at (estop excepted)
//   DUTY_MAX  230  highest duty the output may reach
// PORTS
//   clk        in   1  system clock
//   rst        in   1  synchronous, active-high reset
//   cmd_valid  in   1  cmd_level valid this cycle
//   cmd_ready  out  1  block accepts command; transfer = valid & ready
//   cmd_level  in   W  requested resistance level (raw, unclamped)
//   estop      in   1  emergency stop, level-sensitive, highest priority
//   pwm_duty   out  W  duty to wheel_resistance_driver.PWM_in (registered)
//   busy       out  1  1 while ramping
//   at_target  out  1  one-cycle pulse when pwm_duty reaches target
// BEHAVIOUR
//   Reset (rst=1 at posedge):
//     - state=IDLE; pwm_duty=0; target=0; tick=0; at_target=0.
//     - Reset overrides estop.
//   cmd_ready = !estop && state!=STOP (combinational).
//   Clamp: target <= min(max(cmd_level,DUTY_MIN),DUTY_MAX), registered on transfer.
//   Tick counter:
//     - Free-running 0..RAMP_DIV-1, wraps to 0.
//     - step_en = (tick==RAMP_DIV-1).
//   States:
//     IDLE:
//       - On transfer with clamped value != pwm_duty -> RAMP.
//       - On transfer with clamped value == pwm_duty -> stay IDLE; at_target=1 next cycle.
//     RAMP:
//       - On step_en: pwm_duty steps toward the registered target.
//         - Up: min(duty+STEP,target). Down: max(duty-STEP,target).
//         - Arithmetic in W+1 bits; no wrap, no overshoot.
//       - If the new duty == target: at_target=1 on the same edge, -> IDLE.
//       - A new transfer retargets. The ramp continues from the current duty.
//       - The step taken on the transfer edge uses the old target.
//       - If a retarget equals the current duty: at_target pulse, -> IDLE.
//     STOP:
//       - Entered from any state when estop=1.
//       - pwm_duty=0 and target=0 on the next edge; busy=0.
//       - Commands are not accepted.
//       - estop=0 -> IDLE with duty 0; no at_target pulse.
//   busy = (state==RAMP), registered with state.
//   Latency:
//     - First duty change occurs at the first step_en after transfer (1..RAMP_DIV clocks).
//     - Full-scale ramp takes ceil(|delta|/STEP) steps.
//   Simultaneous events:
//     - estop with cmd_valid: estop wins; no transfer.
//     - estop with step_en: duty=0.
//     - rst beats everything.
// STRUCTURE
//   Package wheel_res_pkg:
//     - W, state enum {IDLE,RAMP,STOP}.
//     - Default DUTY_MIN/DUTY_MAX/STEP constants shared with fan/driver blocks.
//   Sub-module ramp_tick_gen:
//     - Parameterised RAMP_DIV counter with sync reset; outputs step_en.
//   Main FSM, clamp and step arithmetic live in this module.
// TESTING
//   1. Reset, then idle 600 clks -> pwm_duty=0, busy=0, at_target never 1, cmd_ready=1.
//   2. cmd_level=40 accepted -> duty 4,8,...,40 on successive step_en (10 steps).
//      at_target pulses once with duty=40; then IDLE.
//   3. cmd_level=255 -> clamps to 230, ramps and settles at 230.
//      Then cmd_level=3 from 230 -> ramps down, final step lands on 3 (no undershoot).
//   4. Retarget mid-ramp: from 0 toward 200, at duty=100 send 60.
//      -> next steps 96,92,...,60; single at_target pulse.
//   5. estop during ramp at duty=120 with cmd_valid high -> next cycle duty=0, cmd_ready=0.
//      Command not taken. Release -> IDLE, duty stays 0.
//   6. rst asserted mid-ramp -> next cycle all outputs at reset values; tick restarts at 0.
//      Command equal to current duty -> at_target pulse, busy stays 0.

Source files
------------

// File: rtl/wheel_res_pkg.sv
// Shared constants and state encoding for the wheel resistance path
// (controller, driver and fan blocks agree on these defaults).
package wheel_res_pkg;

  localparam int W            = 8;
  localparam int RAMP_DIV_DEF = 256;
  localparam int STEP_DEF     = 4;
  localparam int DUTY_MIN_DEF = 0;
  localparam int DUTY_MAX_DEF = 230;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    STOP = 2'd2
  } state_e;

endpackage

// File: rtl/ramp_tick_gen.sv
// Free-running divider that flags the last clock of every ramp period.
module ramp_tick_gen #(
  parameter int RAMP_DIV = 256
) (
  input  logic clk,
  input  logic rst,
  output logic step_en
);

  localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(RAMP_DIV - 1);

  logic [CW-1:0] tick_q;
  logic [CW-1:0] tick_d;

  always_comb begin
    tick_d = (tick_q == LAST) ? '0 : tick_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) tick_q <= '0;
    else     tick_q <= tick_d;
  end

  assign step_en = (tick_q == LAST);

endmodule

// File: rtl/wheel_resistance_controller.sv
// Turns resistance commands into a clamped, slew-limited PWM duty word for the
// wheel resistance driver, with an emergency stop that zeroes it at once.
module wheel_resistance_controller #(
  parameter int W        = wheel_res_pkg::W,
  parameter int RAMP_DIV = wheel_res_pkg::RAMP_DIV_DEF,
  parameter int STEP     = wheel_res_pkg::STEP_DEF,
  parameter int DUTY_MIN = wheel_res_pkg::DUTY_MIN_DEF,
  parameter int DUTY_MAX = wheel_res_pkg::DUTY_MAX_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_level,
  input  logic         estop,
  output logic [W-1:0] pwm_duty,
  output logic         busy,
  output logic         at_target
);

  import wheel_res_pkg::*;

  localparam logic [W-1:0] MIN_V  = W'(DUTY_MIN);
  localparam logic [W-1:0] MAX_V  = W'(DUTY_MAX);
  localparam logic [W:0]   STEP_V = (W+1)'(STEP);

  state_e       state_q;
  logic [W-1:0] duty_q;
  logic [W-1:0] target_q;
  logic         at_target_q;
  logic         busy_q;

  logic         step_en;
  logic         transfer;
  logic [W-1:0] clamped;
  logic [W-1:0] stepped;
  logic [W-1:0] duty_d;

  ramp_tick_gen #(
    .RAMP_DIV (RAMP_DIV)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .step_en (step_en)
  );

  assign cmd_ready = !estop && (state_q != STOP);
  assign transfer  = cmd_valid && cmd_ready;

  always_comb begin
    clamped = cmd_level;
    if (cmd_level <= MIN_V) clamped = MIN_V;
    if (cmd_level >= MAX_V) clamped = MAX_V;
  end

  // Widened compares so duty+STEP can never wrap past the top of the range.
  always_comb begin
    stepped = duty_q;
    if (target_q > duty_q) begin
      if (({1'b0, duty_q} + STEP_V) >= {1'b0, target_q}) stepped = target_q;
      else                                                stepped = duty_q + STEP_V[W-1:0];
    end else if (target_q < duty_q) begin
      if ({1'b0, duty_q} <= ({1'b0, target_q} + STEP_V)) stepped = target_q;
      else                                                stepped = duty_q - STEP_V[W-1:0];
    end
  end

  assign duty_d = step_en ? stepped : duty_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      duty_q      <= '0;
      target_q    <= '0;
      at_target_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (estop) begin
      state_q     <= STOP;
      duty_q      <= '0;
      target_q    <= '0;
      at_target_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      at_target_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (transfer) begin
            target_q <= clamped;
            if (clamped == duty_q) begin
              at_target_q <= 1'b1;
            end else begin
              state_q <= RAMP;
              busy_q  <= 1'b1;
            end
          end
        end
        RAMP: begin
          // A step coinciding with a retarget still heads for the old target.
          duty_q <= duty_d;
          if (transfer) begin
            target_q <= clamped;
            if (clamped == duty_d) begin
              at_target_q <= 1'b1;
              state_q     <= IDLE;
              busy_q      <= 1'b0;
            end
          end else if (step_en && (duty_d == target_q)) begin
            at_target_q <= 1'b1;
            state_q     <= IDLE;
            busy_q      <= 1'b0;
          end
        end
        STOP: begin
          state_q  <= IDLE;
          duty_q   <= '0;
          target_q <= '0;
          busy_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pwm_duty  = duty_q;
  assign busy      = busy_q;
  assign at_target = at_target_q;

endmodule

// File: tb/tb_wheel_resistance_controller.sv
// Directed bench for wheel_resistance_controller: ramps, clamping, retarget,
// emergency stop and reset behaviour with hand-computed expectations.
`timescale 1ns/1ps
module tb_wheel_resistance_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_level;
  logic       estop;
  logic [7:0] pwm_duty;
  logic       busy;
  logic       at_target;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wheel_resistance_controller dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_level (cmd_level),
    .estop     (estop),
    .pwm_duty  (pwm_duty),
    .busy      (busy),
    .at_target (at_target)
  );

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clk1();
    rst = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] lvl);
    cmd_valid = 1'b1;
    cmd_level = lvl;
    clk1();
    cmd_valid = 1'b0;
  endtask

  // Waits (bounded) for pwm_duty to change; n = clocks taken, -1 on timeout.
  task automatic wait_change(output logic [7:0] d, output int n,
                             output logic at, output logic stray);
    logic [7:0] prev;
    prev  = pwm_duty;
    d     = prev;
    n     = -1;
    at    = 1'b0;
    stray = 1'b0;
    for (int i = 1; i <= 600; i++) begin
      clk1();
      if (pwm_duty !== prev) begin
        d  = pwm_duty;
        n  = i;
        at = at_target;
        break;
      end
      if (at_target !== 1'b0) stray = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic bad_duty, bad_busy, bad_at;
    rst = 1'b1; estop = 1'b1; cmd_valid = 1'b1; cmd_level = 8'd100;
    clk1();
    clk1();
    n_cmp++; if (pwm_duty !== 8'd0) begin n_bad++; $display("FAIL reset_duty: got %0d want 0", pwm_duty); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++; if (at_target !== 1'b0) begin n_bad++; $display("FAIL reset_at: got %0b want 0", at_target); end
    estop = 1'b0; cmd_valid = 1'b0; cmd_level = 8'd0;
    clk1();
    rst = 1'b0;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %0b want 1", cmd_ready); end
    bad_duty = 0; bad_busy = 0; bad_at = 0;
    for (int i = 0; i < 600; i++) begin
      clk1();
      if (pwm_duty !== 8'd0) bad_duty = 1;
      if (busy !== 1'b0) bad_busy = 1;
      if (at_target !== 1'b0) bad_at = 1;
    end
    n_cmp++; if (bad_duty !== 1'b0) begin n_bad++; $display("FAIL idle_duty: got nonzero duty want 0"); end
    n_cmp++; if (bad_busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got busy=1 want 0"); end
    n_cmp++; if (bad_at !== 1'b0) begin n_bad++; $display("FAIL idle_at: got at_target=1 want 0"); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready: got %0b want 1", cmd_ready); end
    $display("test_reset done: duty=%0d busy=%0b ready=%0b", pwm_duty, busy, cmd_ready);
  endtask

  // Full ramp from start to tgt in nsteps steps of 4, one per 256-clock period.
  task automatic run_ramp(input string name, input logic [7:0] start, input logic [7:0] lvl,
                          input logic [7:0] tgt, input int nsteps);
    int exp_d, n, k;
    logic [7:0] d;
    logic at, stray;
    exp_d = start;
    send_cmd(lvl);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL %s_busy_start: got %0b want 1", name, busy); end
    k = 0;
    while (exp_d != tgt) begin
      if (tgt > exp_d) exp_d = (exp_d + 4 >= tgt) ? tgt : exp_d + 4;
      else             exp_d = (exp_d <= tgt + 4) ? tgt : exp_d - 4;
      k++;
      wait_change(d, n, at, stray);
      n_cmp++; if (d !== exp_d[7:0]) begin n_bad++; $display("FAIL %s_step%0d_duty: got %0d want %0d", name, k, d, exp_d); end
      n_cmp++;
      if (k == 1) begin
        if (n < 1 || n > 256) begin n_bad++; $display("FAIL %s_first_latency: got %0d want 1..256", name, n); end
      end else if (n !== 256) begin
        n_bad++; $display("FAIL %s_step%0d_spacing: got %0d want 256", name, k, n);
      end
      n_cmp++; if (at !== (exp_d == tgt)) begin n_bad++; $display("FAIL %s_step%0d_at: got %0b want %0b", name, k, at, exp_d == tgt); end
      n_cmp++; if (stray !== 1'b0) begin n_bad++; $display("FAIL %s_step%0d_stray_at: got 1 want 0", name, k); end
      if (n < 0) break;
    end
    n_cmp++; if (k !== nsteps) begin n_bad++; $display("FAIL %s_nsteps: got %0d want %0d", name, k, nsteps); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s_busy_end: got %0b want 0", name, busy); end
    clk1();
    n_cmp++; if (at_target !== 1'b0) begin n_bad++; $display("FAIL %s_at_single: got %0b want 0", name, at_target); end
    $display("%s: cmd=%0d settled duty=%0d after %0d steps", name, lvl, pwm_duty, k);
  endtask

  task automatic test_ramp_up();
    run_ramp("ramp40", 8'd0, 8'd40, 8'd40, 10);
  endtask

  task automatic test_clamp_and_down();
    run_ramp("clamp255", 8'd40, 8'd255, 8'd230, 48);
    run_ramp("down3", 8'd230, 8'd3, 8'd3, 57);
  endtask

  task automatic test_retarget();
    logic [7:0] d;
    int n, exp_d;
    logic at, stray;
    do_reset();
    send_cmd(8'd200);
    for (int k = 1; k <= 25; k++) begin
      wait_change(d, n, at, stray);
      if (n < 0) break;
    end
    n_cmp++; if (d !== 8'd100) begin n_bad++; $display("FAIL retarget_reach100: got %0d want 100", d); end
    send_cmd(8'd60);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL retarget_busy: got %0b want 1", busy); end
    n_cmp++; if (pwm_duty !== 8'd100) begin n_bad++; $display("FAIL retarget_hold: got %0d want 100", pwm_duty); end
    exp_d = 100;
    for (int k = 1; k <= 10; k++) begin
      exp_d = exp_d - 4;
      wait_change(d, n, at, stray);
      n_cmp++; if (d !== exp_d[7:0]) begin n_bad++; $display("FAIL retarget_step%0d_duty: got %0d want %0d", k, d, exp_d); end
      n_cmp++; if (n !== ((k == 1) ? 255 : 256)) begin n_bad++; $display("FAIL retarget_step%0d_spacing: got %0d want %0d", k, n, (k == 1) ? 255 : 256); end
      n_cmp++; if (at !== (k == 10)) begin n_bad++; $display("FAIL retarget_step%0d_at: got %0b want %0b", k, at, k == 10); end
      n_cmp++; if (stray !== 1'b0) begin n_bad++; $display("FAIL retarget_step%0d_stray_at: got 1 want 0", k); end
      if (n < 0) break;
    end
    clk1();
    n_cmp++; if (at_target !== 1'b0) begin n_bad++; $display("FAIL retarget_at_single: got %0b want 0", at_target); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL retarget_busy_end: got %0b want 0", busy); end
    $display("test_retarget: 200 -> 60 at duty 100, settled duty=%0d", pwm_duty);
  endtask

  task automatic test_estop();
    logic [7:0] d;
    int n;
    logic at, stray, bad_duty, bad_at, bad_busy;
    do_reset();
    send_cmd(8'd200);
    for (int k = 1; k <= 30; k++) begin
      wait_change(d, n, at, stray);
      if (n < 0) break;
    end
    n_cmp++; if (d !== 8'd120) begin n_bad++; $display("FAIL estop_reach120: got %0d want 120", d); end
    estop = 1'b1; cmd_valid = 1'b1; cmd_level = 8'd50;
    #1;
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL estop_ready_comb: got %0b want 0", cmd_ready); end
    clk1();
    n_cmp++; if (pwm_duty !== 8'd0) begin n_bad++; $display("FAIL estop_duty: got %0d want 0", pwm_duty); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL estop_busy: got %0b want 0", busy); end
    n_cmp++; if (at_target !== 1'b0) begin n_bad++; $display("FAIL estop_at: got %0b want 0", at_target); end
    bad_duty = 0;
    for (int i = 0; i < 300; i++) begin
      clk1();
      if (pwm_duty !== 8'd0 || cmd_ready !== 1'b0) bad_duty = 1;
    end
    n_cmp++; if (bad_duty !== 1'b0) begin n_bad++; $display("FAIL estop_hold: got duty/ready active want 0/0"); end
    estop = 1'b0; cmd_valid = 1'b0;
    #1;
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL estop_still_stop: got %0b want 0", cmd_ready); end
    clk1();
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL estop_release_ready: got %0b want 1", cmd_ready); end
    n_cmp++; if (at_target !== 1'b0) begin n_bad++; $display("FAIL estop_release_at: got %0b want 0", at_target); end
    bad_duty = 0; bad_at = 0; bad_busy = 0;
    for (int i = 0; i < 300; i++) begin
      clk1();
      if (pwm_duty !== 8'd0) bad_duty = 1;
      if (at_target !== 1'b0) bad_at = 1;
      if (busy !== 1'b0) bad_busy = 1;
    end
    n_cmp++; if (bad_duty !== 1'b0) begin n_bad++; $display("FAIL estop_after_duty: got nonzero want 0"); end
    n_cmp++; if (bad_at !== 1'b0) begin n_bad++; $display("FAIL estop_after_at: got 1 want 0"); end
    n_cmp++; if (bad_busy !== 1'b0) begin n_bad++; $display("FAIL estop_after_busy: got 1 want 0"); end
    $display("test_estop: stopped from 120, released, duty=%0d ready=%0b", pwm_duty, cmd_ready);
  endtask

  task automatic test_reset_mid_ramp();
    logic [7:0] d;
    int n;
    logic at, stray;
    do_reset();
    send_cmd(8'd200);
    for (int k = 1; k <= 3; k++) begin
      wait_change(d, n, at, stray);
      if (n < 0) break;
    end
    n_cmp++; if (d !== 8'd12) begin n_bad++; $display("FAIL midrst_reach12: got %0d want 12", d); end
    rst = 1'b1;
    clk1();
    rst = 1'b0;
    n_cmp++; if (pwm_duty !== 8'd0) begin n_bad++; $display("FAIL midrst_duty: got %0d want 0", pwm_duty); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %0b want 0", busy); end
    n_cmp++; if (at_target !== 1'b0) begin n_bad++; $display("FAIL midrst_at: got %0b want 0", at_target); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %0b want 1", cmd_ready); end
    send_cmd(8'd0);
    n_cmp++; if (at_target !== 1'b1) begin n_bad++; $display("FAIL equal_cmd_at: got %0b want 1", at_target); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL equal_cmd_busy: got %0b want 0", busy); end
    send_cmd(8'd8);
    n_cmp++; if (at_target !== 1'b0) begin n_bad++; $display("FAIL equal_cmd_pulse_len: got %0b want 0", at_target); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL tick_restart_busy: got %0b want 1", busy); end
    wait_change(d, n, at, stray);
    n_cmp++; if (d !== 8'd4) begin n_bad++; $display("FAIL tick_restart_duty: got %0d want 4", d); end
    n_cmp++; if (n !== 254) begin n_bad++; $display("FAIL tick_restart_latency: got %0d want 254", n); end
    wait_change(d, n, at, stray);
    n_cmp++; if (d !== 8'd8) begin n_bad++; $display("FAIL tick_restart_final: got %0d want 8", d); end
    n_cmp++; if (at !== 1'b1) begin n_bad++; $display("FAIL tick_restart_at: got %0b want 1", at); end
    $display("test_reset_mid_ramp: duty=%0d busy=%0b", pwm_duty, busy);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_level = 8'd0; estop = 1'b0;
    test_reset();
    test_ramp_up();
    test_clamp_and_down();
    test_retarget();
    test_estop();
    test_reset_mid_ramp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
